// File: rtl/spi_cmd_ram_if.sv
// Command/response bundle between the SPI slave shift logic and the command RAM.
// The RAM is the slave: it consumes command words and produces read data.
interface spi_cmd_ram_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W+1:0] din;
   logic              rx_valid_ram;
   logic [DATA_W-1:0] dout;
   logic              tx_valid_ram;
   logic              tx_ready_ram;
   logic              rd_overrun;

   modport master (
      output din, rx_valid_ram, tx_ready_ram,
      input  dout, tx_valid_ram, rd_overrun
   );

   modport slave (
      input  din, rx_valid_ram, tx_ready_ram,
      output dout, tx_valid_ram, rd_overrun
   );
endinterface

// File: rtl/spi_cmd_ram.sv
// Command-decoded single-port RAM with independent write/read pointers,
// optional pointer auto-increment and a valid/ready read port with sticky overrun.
module spi_cmd_ram #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 8,
   parameter int AUTO_INC = 1
) (
   input  logic          clk_ram,
   input  logic          rst_ram,
   spi_cmd_ram_if.slave  bus
);
   localparam int MEM_DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      OP_WR_ADDR = 2'b00,
      OP_WR_DATA = 2'b01,
      OP_RD_ADDR = 2'b10,
      OP_RD_DATA = 2'b11
   } opcode_t;

   logic [DATA_W-1:0] r_mem [MEM_DEPTH];
   logic [ADDR_W-1:0] r_wrAdd;
   logic [ADDR_W-1:0] r_rdAdd;
   logic [DATA_W-1:0] r_dout;
   logic              r_txValid;
   logic              r_overrun;

   opcode_t           w_op;
   logic [DATA_W-1:0] w_payload;
   logic              w_wrAddCmd;
   logic              w_wrDataCmd;
   logic              w_rdAddCmd;
   logic              w_rdCmd;
   logic              w_rdAccept;
   logic              w_incEn;

   assign w_op        = opcode_t'(bus.din[DATA_W+1:DATA_W]);
   assign w_payload   = bus.din[DATA_W-1:0];
   assign w_wrAddCmd  = bus.rx_valid_ram && (w_op == OP_WR_ADDR);
   assign w_wrDataCmd = bus.rx_valid_ram && (w_op == OP_WR_DATA);
   assign w_rdAddCmd  = bus.rx_valid_ram && (w_op == OP_RD_ADDR);
   assign w_rdCmd     = bus.rx_valid_ram && (w_op == OP_RD_DATA);
   assign w_incEn     = (AUTO_INC != 0);

   // A read may enter the output register when it is empty or being drained this cycle.
   assign w_rdAccept  = w_rdCmd && (!r_txValid || bus.tx_ready_ram);

   // Storage has no reset so it maps onto plain RAM; reset still suppresses writes.
   always_ff @(posedge clk_ram) begin
      if (!rst_ram && w_wrDataCmd) begin
         r_mem[r_wrAdd] <= w_payload;
      end
   end

   always_ff @(posedge clk_ram) begin
      if (rst_ram) begin
         r_wrAdd   <= '0;
         r_rdAdd   <= '0;
         r_dout    <= '0;
         r_txValid <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (w_wrAddCmd) begin
            r_wrAdd <= w_payload[ADDR_W-1:0];
         end else if (w_wrDataCmd && w_incEn) begin
            r_wrAdd <= r_wrAdd + ADDR_W'(1);
         end

         if (w_rdAddCmd) begin
            r_rdAdd <= w_payload[ADDR_W-1:0];
         end else if (w_rdAccept && w_incEn) begin
            r_rdAdd <= r_rdAdd + ADDR_W'(1);
         end

         // A new word takes priority over the drain so valid stays high in bursts.
         if (w_rdAccept) begin
            r_dout    <= r_mem[r_rdAdd];
            r_txValid <= 1'b1;
         end else if (r_txValid && bus.tx_ready_ram) begin
            r_txValid <= 1'b0;
         end

         if (w_rdCmd && !w_rdAccept) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign bus.dout         = r_dout;
   assign bus.tx_valid_ram = r_txValid;
   assign bus.rd_overrun   = r_overrun;
endmodule

// File: tb/tb_spi_cmd_ram.sv
// Directed bench for spi_cmd_ram: an 8/8 auto-increment instance and a
// 16/4 fixed-pointer instance share the clock and reset.
module tb_spi_cmd_ram;
   logic clk_ram = 1'b0;
   logic rst_ram;

   int checks = 0;
   int errors = 0;

   spi_cmd_ram_if #(.DATA_W(8))  bus8 ();
   spi_cmd_ram_if #(.DATA_W(16)) bus16 ();

   spi_cmd_ram #(.DATA_W(8), .ADDR_W(8), .AUTO_INC(1)) dut8 (
      .clk_ram (clk_ram),
      .rst_ram (rst_ram),
      .bus     (bus8)
   );

   spi_cmd_ram #(.DATA_W(16), .ADDR_W(4), .AUTO_INC(0)) dut16 (
      .clk_ram (clk_ram),
      .rst_ram (rst_ram),
      .bus     (bus16)
   );

   always #5 clk_ram = ~clk_ram;

   // Drive one cycle on the 8-bit instance, then step to 1 time unit past the edge.
   task automatic applyStimulus(input logic valid, input logic [1:0] op,
                                input logic [7:0] payload, input logic ready);
      bus8.rx_valid_ram = valid;
      bus8.din          = {op, payload};
      bus8.tx_ready_ram = ready;
      @(posedge clk_ram);
      #1;
      bus8.rx_valid_ram = 1'b0;
   endtask

   task automatic applyStimulus16(input logic valid, input logic [1:0] op,
                                  input logic [15:0] payload, input logic ready);
      bus16.rx_valid_ram = valid;
      bus16.din          = {op, payload};
      bus16.tx_ready_ram = ready;
      @(posedge clk_ram);
      #1;
      bus16.rx_valid_ram = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      bus8.rx_valid_ram  = 1'b0;
      bus8.din           = '0;
      bus8.tx_ready_ram  = 1'b0;
      bus16.rx_valid_ram = 1'b0;
      bus16.din          = '0;
      bus16.tx_ready_ram = 1'b0;

      rst_ram = 1'b1;
      @(posedge clk_ram);
      #1;
      checkOutput("rst_dout",    16'(bus8.dout), 16'h00);
      checkOutput("rst_valid",   16'(bus8.tx_valid_ram), 16'h0);
      checkOutput("rst_overrun", 16'(bus8.rd_overrun), 16'h0);
      checkOutput("rst16_valid", 16'(bus16.tx_valid_ram), 16'h0);
      rst_ram = 1'b0;

      $display("[TB] burst write/read with auto-increment");
      applyStimulus(1'b1, 2'b00, 8'h10, 1'b1);
      applyStimulus(1'b1, 2'b01, 8'hA1, 1'b1);
      applyStimulus(1'b1, 2'b01, 8'hB2, 1'b1);
      applyStimulus(1'b1, 2'b01, 8'hC3, 1'b1);
      checkOutput("write_no_valid", 16'(bus8.tx_valid_ram), 16'h0);
      applyStimulus(1'b1, 2'b10, 8'h10, 1'b1);
      applyStimulus(1'b1, 2'b11, 8'h00, 1'b1);
      checkOutput("burst0_dout",  16'(bus8.dout), 16'hA1);
      checkOutput("burst0_valid", 16'(bus8.tx_valid_ram), 16'h1);
      applyStimulus(1'b1, 2'b11, 8'h00, 1'b1);
      checkOutput("burst1_dout",  16'(bus8.dout), 16'hB2);
      checkOutput("burst1_valid", 16'(bus8.tx_valid_ram), 16'h1);
      applyStimulus(1'b1, 2'b11, 8'h00, 1'b1);
      checkOutput("burst2_dout",  16'(bus8.dout), 16'hC3);
      checkOutput("burst2_valid", 16'(bus8.tx_valid_ram), 16'h1);
      checkOutput("burst_overrun", 16'(bus8.rd_overrun), 16'h0);
      applyStimulus(1'b0, 2'b00, 8'h00, 1'b1);
      checkOutput("drain_valid", 16'(bus8.tx_valid_ram), 16'h0);
      checkOutput("drain_dout",  16'(bus8.dout), 16'hC3);

      $display("[TB] pointer wrap-around");
      applyStimulus(1'b1, 2'b00, 8'hFF, 1'b1);
      applyStimulus(1'b1, 2'b01, 8'h11, 1'b1);
      applyStimulus(1'b1, 2'b01, 8'h22, 1'b1);
      applyStimulus(1'b1, 2'b10, 8'hFF, 1'b1);
      applyStimulus(1'b1, 2'b11, 8'h00, 1'b1);
      checkOutput("wrap_ff", 16'(bus8.dout), 16'h11);
      applyStimulus(1'b1, 2'b11, 8'h00, 1'b1);
      checkOutput("wrap_00", 16'(bus8.dout), 16'h22);
      applyStimulus(1'b0, 2'b00, 8'h00, 1'b1);
      checkOutput("wrap_drain", 16'(bus8.tx_valid_ram), 16'h0);

      $display("[TB] overrun");
      applyStimulus(1'b1, 2'b10, 8'h10, 1'b0);
      applyStimulus(1'b0, 2'b00, 8'h00, 1'b1);
      checkOutput("idle_ready_valid", 16'(bus8.tx_valid_ram), 16'h0);
      applyStimulus(1'b1, 2'b11, 8'h00, 1'b0);
      checkOutput("ovr_first_dout",  16'(bus8.dout), 16'hA1);
      checkOutput("ovr_first_flag",  16'(bus8.rd_overrun), 16'h0);
      applyStimulus(1'b1, 2'b11, 8'h00, 1'b0);
      checkOutput("ovr_kept_dout",  16'(bus8.dout), 16'hA1);
      checkOutput("ovr_flag",       16'(bus8.rd_overrun), 16'h1);
      checkOutput("ovr_kept_valid", 16'(bus8.tx_valid_ram), 16'h1);
      applyStimulus(1'b0, 2'b00, 8'h00, 1'b1);
      checkOutput("ovr_drain_valid", 16'(bus8.tx_valid_ram), 16'h0);
      checkOutput("ovr_sticky",      16'(bus8.rd_overrun), 16'h1);
      applyStimulus(1'b1, 2'b11, 8'h00, 1'b0);
      checkOutput("ovr_rdadd_held", 16'(bus8.dout), 16'hB2);
      checkOutput("ovr_sticky2",    16'(bus8.rd_overrun), 16'h1);

      $display("[TB] fixed pointers, 16-bit data");
      applyStimulus16(1'b1, 2'b00, 16'h0003, 1'b1);
      applyStimulus16(1'b1, 2'b01, 16'hBEEF, 1'b1);
      applyStimulus16(1'b1, 2'b01, 16'h1234, 1'b1);
      applyStimulus16(1'b1, 2'b10, 16'h0003, 1'b1);
      applyStimulus16(1'b1, 2'b11, 16'h0000, 1'b1);
      checkOutput("noinc_rd0", bus16.dout, 16'h1234);
      checkOutput("noinc_valid", 16'(bus16.tx_valid_ram), 16'h1);
      applyStimulus16(1'b1, 2'b11, 16'h0000, 1'b1);
      checkOutput("noinc_rd1", bus16.dout, 16'h1234);
      applyStimulus16(1'b1, 2'b00, 16'h0005, 1'b1);
      applyStimulus16(1'b1, 2'b00, 16'hFFF3, 1'b1);
      applyStimulus16(1'b1, 2'b01, 16'h5A5A, 1'b1);
      applyStimulus16(1'b1, 2'b11, 16'h0000, 1'b1);
      checkOutput("upper_ignored", bus16.dout, 16'h5A5A);
      checkOutput("noinc_overrun", 16'(bus16.rd_overrun), 16'h0);

      $display("[TB] reset mid-operation");
      checkOutput("pre_rst_valid", 16'(bus8.tx_valid_ram), 16'h1);
      rst_ram = 1'b1;
      applyStimulus(1'b1, 2'b11, 8'h00, 1'b0);
      checkOutput("midrst_dout",    16'(bus8.dout), 16'h00);
      checkOutput("midrst_valid",   16'(bus8.tx_valid_ram), 16'h0);
      checkOutput("midrst_overrun", 16'(bus8.rd_overrun), 16'h0);
      rst_ram = 1'b0;
      applyStimulus(1'b1, 2'b11, 8'h00, 1'b0);
      checkOutput("retained_mem0", 16'(bus8.dout), 16'h22);
      checkOutput("retained_valid", 16'(bus8.tx_valid_ram), 16'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/spi_cmd_ram.md
# spi_cmd_ram

Parametrised command-decoded single-port RAM. It sits behind the SPI slave shift logic and takes one {opcode, payload} command word per `rx_valid_ram` strobe. Compared with the fixed 8-bit/256-deep RAM, it adds configurable data and address widths and optional address auto-increment for burst transfers. The read path uses a valid/ready handshake with sticky overrun detection, so read data is never silently overwritten.

## Interface
Parameters:
- `DATA_W`, 8: memory word width and command payload width.
- `ADDR_W`, 8: address width. `ADDR_W <= DATA_W` is required. `MEM_DEPTH = 2**ADDR_W`.
- `AUTO_INC`, 1: 1 = write-data and read commands post-increment their address pointer. 0 = pointers change only on address-load commands.

Ports:
- `clk_ram`, in, 1: single clock. All logic is on the rising edge.
- `rst_ram`, in, 1: reset, synchronous and active-high.
- `din`, in, `DATA_W+2`: command word. `din[DATA_W+1:DATA_W]` is the opcode. `din[DATA_W-1:0]` is the payload.
- `rx_valid_ram`, in, 1: `din` is valid this cycle. One command is consumed per high cycle.
- `dout`, out, `DATA_W`: read data register.
- `tx_valid_ram`, out, 1: `dout` holds unconsumed read data.
- `tx_ready_ram`, in, 1: consumer accepts `dout` this cycle.
- `rd_overrun`, out, 1: sticky flag. A read command was dropped because the output register was occupied.

## Operation
- Internal state: `wr_add[ADDR_W-1:0]`, `rd_add[ADDR_W-1:0]`, `mem[MEM_DEPTH]`, the `dout`/`tx_valid_ram` register and `rd_overrun`.
- Commands are evaluated only when `rx_valid_ram=1`. Otherwise no state changes except the handshake clear.
- Opcode 00, address-load write: `wr_add <= din[ADDR_W-1:0]`. Upper payload bits are ignored.
- Opcode 01, write data: `mem[wr_add] <= din[DATA_W-1:0]`. If `AUTO_INC`, also `wr_add <= wr_add+1`.
- Opcode 10, address-load read: `rd_add <= din[ADDR_W-1:0]`.
- Opcode 11, read: the command is accepted if `tx_valid_ram=0`, or if `tx_valid_ram=1` and `tx_ready_ram=1` in the same cycle.
  - Accepted: `dout <= mem[rd_add]` and `tx_valid_ram <= 1`. If `AUTO_INC`, also `rd_add <= rd_add+1`.
  - Not accepted: the command is dropped. `dout`, `tx_valid_ram` and `rd_add` are unchanged, and `rd_overrun <= 1`.
- Handshake: if `tx_valid_ram=1` and `tx_ready_ram=1` and no accepted read occurs that cycle, then `tx_valid_ram <= 0`. `dout` holds its value.
- Pointer arithmetic is modulo `2**ADDR_W`. `MEM_DEPTH-1` increments to 0, with no flag.
- Write and read pointers are independent. Writes never disturb `dout`.
- Read-after-write: a read command at least one cycle after a write to the same address returns the new data.
- `rd_overrun` is cleared only by reset.
- Memory contents are not reset.

## Timing
- Reset, sampled at a rising edge with `rst_ram=1`: `dout=0`, `tx_valid_ram=0`, `rd_overrun=0`, `wr_add=0`, `rd_add=0`.
  - Reset overrides any command or handshake in that cycle.
  - Pending read data is discarded.
  - Memory contents are retained.
- Read latency: a read command sampled at edge N gives `dout`/`tx_valid_ram` valid after edge N, i.e. visible in cycle N+1.
- Address load at edge N: a data or read command at edge N+1 uses the new address. Back-to-back commands every cycle are supported.
- Burst read with `tx_ready_ram` held at 1: one word per cycle, `tx_valid_ram` stays continuously high, and there are no overruns.
- Simultaneous events in one cycle, with `tx_valid_ram=1`, `tx_ready_ram=1` and a read command: the old word is consumed, the new word is loaded, and `tx_valid_ram` stays 1.
- `tx_ready_ram` while `tx_valid_ram=0` has no effect.

## Test plan
- Reset, then `DATA_W=8`, `ADDR_W=8`, `AUTO_INC=1`. Issue 00/0x10, then 01/0xA1, 01/0xB2, 01/0xC3, then 10/0x10, then three 11 commands with `tx_ready_ram=1` -> `dout` is 0xA1, 0xB2, 0xC3 on consecutive cycles, `tx_valid_ram` stays high, `rd_overrun=0`.
- Wrap-around: 00/0xFF, 01/0x11, 01/0x22, then 10/0xFF and two reads -> 0x11 then 0x22. `mem[0]` is 0x22.
- Overrun: read with `tx_ready_ram=0`, then a second read -> `dout` keeps the first word and `rd_overrun=1`. Then `tx_ready_ram=1` for one cycle -> `tx_valid_ram=0`. `rd_overrun` stays 1 until reset.
- `AUTO_INC=0`, `DATA_W=16`, `ADDR_W=4`: 00/0x3, then 01/0xBEEF, 01/0x1234, then 10/0x3 and two reads -> `dout` is 0x1234 twice. Upper payload bits of the address load are ignored: 00/0xFFF3 also selects address 3.
- Reset mid-operation: assert `rst_ram` while `tx_valid_ram=1` and a read command is present -> after the edge, all outputs are 0. A subsequent read at `rd_add=0` returns the retained `mem[0]`.
